ddmtd_phase_accum: RTL and testbench
====================================

# ddmtd_phase_accum

Consumer of the DDMTD phase-sample stream: it takes every `phase_diff` strobe from the `ddmtd` block, accumulates fixed-size windows of 2^LOG2_AVG samples, and publishes per-window mean (optionally min/max) over a valid/ready report interface. It sits in the `clk_ddmtd` domain directly after `ddmtd` and feeds the readout/logging logic. It absorbs per-sample jitter so the downstream only sees one report per window.

## Interface
- `SAMPLE_BIT_WIDTH`, default 16: width of the signed phase sample, equal to `ddmtd` COUNTER_BIT_WIDTH.
- `LOG2_AVG`, default 4: window size N = 2^LOG2_AVG samples; legal range 1..8.
- `clk_ddmtd_i`  in  1: DDMTD offset clock; the only clock.
- `rst_ddmtdclk_i`  in  1: synchronous, active-high reset.
- `phase_diff_i`  in  SAMPLE_BIT_WIDTH: signed phase sample from `ddmtd`.
- `phase_diff_p_i`  in  1: single-cycle strobe; sample valid this cycle.
- `report_ready_i`  in  1: downstream accepts the report.
- `report_valid_o`  out  1: report registers hold an unconsumed window result.
- `mean_o`  out  SAMPLE_BIT_WIDTH: signed window mean.
- `min_o`  out  SAMPLE_BIT_WIDTH: signed window minimum.
- `max_o`  out  SAMPLE_BIT_WIDTH: signed window maximum.
- `overrun_cnt_o`  out  8: saturating count of windows dropped because the report was not consumed.

## Operation
- Accumulator: signed `sum` of width SAMPLE_BIT_WIDTH+LOG2_AVG, sample counter `cnt` of width LOG2_AVG+1. Each strobe adds the sign-extended sample; overflow is impossible by width.
- Window close: the strobe that makes `cnt` reach N computes `sum + sample`, then `mean = (sum + sample) >>> LOG2_AVG`. This is an arithmetic shift, so the result is floored toward minus infinity. The same cycle clears `sum`/`cnt` so the next strobe starts a new window. No sample is ever lost between windows.
- Report FSM, two states:
  - EMPTY: `report_valid_o`=0. Window close loads mean/min/max and moves to FULL.
  - FULL: `report_valid_o`=1. `report_ready_i`=1 with no window close returns to EMPTY.
  - Window close and `report_ready_i` in the same cycle: load the new result and stay FULL, with no bubble.
  - Window close without `report_ready_i`: the new result is discarded, the held report is unchanged, and `overrun_cnt_o` increments, saturating at 255.
- Report registers change only on load; they are stable while `report_valid_o`=1 and not accepted.
- Strobes arriving during FULL keep accumulating into the next window.
- Reset: `sum`, `cnt` and `overrun_cnt_o` go to 0, `report_valid_o`=0, `mean_o`/`min_o`/`max_o`=0, state EMPTY. Reset mid-window discards the partial window. Reset has priority over a coincident strobe.

## Timing
- Single-cycle strobe to register update; no combinational path from inputs to outputs.
- `report_valid_o` rises on the clock edge after the N-th strobe, so latency is 1 cycle from the last sample.
- Back-to-back strobes on consecutive cycles are supported at full rate.
- Handshake completes on the edge where `report_valid_o` and `report_ready_i` are both 1. The `ready` signal may be asserted before `valid`.

## Configuration
- `DDMTD_ACCUM_MINMAX_EN` defined: running min/max registers are compiled in.
  - They are reset per window to the first sample of that window.
  - They update with signed compares on every strobe.
  - They are loaded to `min_o`/`max_o` on window close.
- Not defined: min/max logic is absent and `min_o`/`max_o` are constant 0. Mean, handshake and overrun behaviour are identical.

## Test plan
All scenarios use SAMPLE_BIT_WIDTH=16 and LOG2_AVG=4 (N=16).
- 16 strobes of -3 with `report_ready_i`=1 -> one `report_valid_o` pulse, 1 cycle after the 16th strobe. `mean_o`=-3 (0xFFFD); with the macro, `min_o`=`max_o`=-3.
- 16 strobes alternating 1,2 -> `mean_o`=1 (floor of 1.5). 16 strobes alternating -1,-2 -> `mean_o`=-2. With the macro, `min_o`/`max_o`=1/2 and -2/-1.
- Extreme values: 8 strobes of 32767 and 8 of -32768 -> `mean_o`=-1, showing no overflow and floored rounding. With the macro, `min_o`=-32768 and `max_o`=32767.
- `report_ready_i`=0 over 3 full windows -> the first report is held unchanged and `overrun_cnt_o`=2. Raising `ready` -> one handshake, `report_valid_o` falls, and the next window reports normally.
- Window close in the same cycle as handshake acceptance -> `report_valid_o` stays 1 and the outputs switch to the new window's values.
- Reset asserted after 7 strobes, then 16 strobes of 5 -> `mean_o`=5 with no contribution from the pre-reset samples. All outputs read 0 during reset.

Source files
------------

// File: rtl/ddmtd_phase_accum.sv
// Windowed averager for the DDMTD phase-sample stream: mean (and optional min/max) per 2^LOG2_AVG samples.
// Optional feature macro: DDMTD_ACCUM_MINMAX_EN compiles in the running min/max tracking.
module ddmtd_phase_accum #(
  parameter int SAMPLE_BIT_WIDTH = 16,
  parameter int LOG2_AVG         = 4
) (
  input  logic                               clk_ddmtd_i,
  input  logic                               rst_ddmtdclk_i,
  input  logic signed [SAMPLE_BIT_WIDTH-1:0] phase_diff_i,
  input  logic                               phase_diff_p_i,
  input  logic                               report_ready_i,
  output logic                               report_valid_o,
  output logic signed [SAMPLE_BIT_WIDTH-1:0] mean_o,
  output logic signed [SAMPLE_BIT_WIDTH-1:0] min_o,
  output logic signed [SAMPLE_BIT_WIDTH-1:0] max_o,
  output logic        [7:0]                  overrun_cnt_o
);

  localparam int SUM_W = SAMPLE_BIT_WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                      state_q;
  logic signed [SUM_W-1:0]     sum_q, sum_d;
  logic        [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [SUM_W-1:0]     sampleExt;
  logic signed [SUM_W-1:0]     sumNext;
  logic signed [SAMPLE_BIT_WIDTH-1:0] meanNext;
  logic                        windowClose;
  logic                        loadReport;
  logic signed [SAMPLE_BIT_WIDTH-1:0] mean_q;
  logic        [7:0]           overrun_q;

  assign sampleExt = {{LOG2_AVG{phase_diff_i[SAMPLE_BIT_WIDTH-1]}}, phase_diff_i};
  assign sumNext   = sum_q + sampleExt;
  // Dropping the low LOG2_AVG bits of the full-width sum is an arithmetic shift, i.e. floor.
  assign meanNext  = sumNext[LOG2_AVG +: SAMPLE_BIT_WIDTH];

  always_comb begin
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    windowClose = 1'b0;
    if (phase_diff_p_i) begin
      if (cnt_q == LAST_CNT) begin
        windowClose = 1'b1;
        sum_d       = '0;
        cnt_d       = '0;
      end else begin
        sum_d = sumNext;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ddmtd_i) begin
    if (rst_ddmtdclk_i) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // A closing window is taken if the slot is free or the held report is consumed on this same edge.
  assign loadReport = windowClose && ((state_q == EMPTY) || report_ready_i);

  always_ff @(posedge clk_ddmtd_i) begin
    if (rst_ddmtdclk_i) begin
      state_q   <= EMPTY;
      mean_q    <= '0;
      overrun_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (windowClose) begin
            mean_q  <= meanNext;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (windowClose) begin
            if (report_ready_i) begin
              mean_q <= meanNext;
            end else if (overrun_q != 8'hFF) begin
              overrun_q <= overrun_q + 8'd1;
            end
          end else if (report_ready_i) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign report_valid_o = (state_q == FULL);
  assign mean_o         = mean_q;
  assign overrun_cnt_o  = overrun_q;

`ifdef DDMTD_ACCUM_MINMAX_EN
  logic signed [SAMPLE_BIT_WIDTH-1:0] runMin_q, runMax_q;
  logic signed [SAMPLE_BIT_WIDTH-1:0] minNext, maxNext;
  logic signed [SAMPLE_BIT_WIDTH-1:0] min_q, max_q;

  // The first sample of a window seeds the running extremes.
  always_comb begin
    minNext = phase_diff_i;
    maxNext = phase_diff_i;
    if (cnt_q != '0) begin
      if (runMin_q < phase_diff_i) minNext = runMin_q;
      if (runMax_q > phase_diff_i) maxNext = runMax_q;
    end
  end

  always_ff @(posedge clk_ddmtd_i) begin
    if (rst_ddmtdclk_i) begin
      runMin_q <= '0;
      runMax_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
    end else begin
      if (phase_diff_p_i) begin
        runMin_q <= minNext;
        runMax_q <= maxNext;
      end
      if (loadReport) begin
        min_q <= minNext;
        max_q <= maxNext;
      end
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`else
  logic unusedLoad;
  assign unusedLoad = loadReport;
  assign min_o      = '0;
  assign max_o      = '0;
`endif

endmodule

// File: tb/tb_ddmtd_phase_accum.sv
// Directed self-checking bench for ddmtd_phase_accum with N=16; honours DDMTD_ACCUM_MINMAX_EN for min/max expectations.
module tb_ddmtd_phase_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] phaseDiff;
  logic               phaseStrobe;
  logic               reportReady;
  logic               reportValid;
  logic signed [15:0] meanOut;
  logic signed [15:0] minOut;
  logic signed [15:0] maxOut;
  logic        [7:0]  overrunCnt;

  int checks   = 0;
  int failures = 0;
  logic signed [15:0] win [16];

  ddmtd_phase_accum #(.SAMPLE_BIT_WIDTH(16), .LOG2_AVG(4)) dut (
    .clk_ddmtd_i    (clk),
    .rst_ddmtdclk_i (rst),
    .phase_diff_i   (phaseDiff),
    .phase_diff_p_i (phaseStrobe),
    .report_ready_i (reportReady),
    .report_valid_o (reportValid),
    .mean_o         (meanOut),
    .min_o          (minOut),
    .max_o          (maxOut),
    .overrun_cnt_o  (overrunCnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic feedWindow();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      phaseStrobe = 1'b1;
      phaseDiff   = win[i];
    end
    @(negedge clk);
    phaseStrobe = 1'b0;
  endtask

  task automatic fillConst(input logic signed [15:0] v);
    for (int i = 0; i < 16; i++) win[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; phaseStrobe = 1'b0; phaseDiff = '0; reportReady = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (reportValid !== 1'b0 || meanOut !== 16'sd0 || minOut !== 16'sd0 ||
        maxOut !== 16'sd0 || overrunCnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid=%b mean=%0d min=%0d max=%0d ovr=%0d, expected all 0",
               reportValid, meanOut, minOut, maxOut, overrunCnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_constant();
    logic sawEarly = 1'b0;
    reportReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (reportValid) sawEarly = 1'b1;
      phaseStrobe = 1'b1;
      phaseDiff   = -16'sd3;
    end
    @(negedge clk);
    phaseStrobe = 1'b0;
    checks++;
    if (sawEarly !== 1'b0) begin
      failures++;
      $display("[TB] FAIL const_early_valid: valid seen before window close=%b, expected 0", sawEarly);
    end
    checks++;
    if (reportValid !== 1'b1 || meanOut !== -16'sd3) begin
      failures++;
      $display("[TB] FAIL const_mean: valid=%b mean=%0d, expected valid=1 mean=-3", reportValid, meanOut);
    end
`ifdef DDMTD_ACCUM_MINMAX_EN
    checks++;
    if (minOut !== -16'sd3 || maxOut !== -16'sd3) begin
      failures++;
      $display("[TB] FAIL const_minmax: min=%0d max=%0d, expected -3/-3", minOut, maxOut);
    end
`endif
    @(negedge clk);
    checks++;
    if (reportValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL const_pulse_len: valid=%b one cycle later, expected 0", reportValid);
    end
  endtask

  task automatic test_alternating();
    logic signed [15:0] expMin, expMax;
    reportReady = 1'b1;
    for (int i = 0; i < 16; i++) win[i] = (i % 2 == 0) ? 16'sd1 : 16'sd2;
    feedWindow();
    expMin = 16'sd0; expMax = 16'sd0;
`ifdef DDMTD_ACCUM_MINMAX_EN
    expMin = 16'sd1; expMax = 16'sd2;
`endif
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd1 || minOut !== expMin || maxOut !== expMax) begin
      failures++;
      $display("[TB] FAIL alt_pos: valid=%b mean=%0d min=%0d max=%0d, expected 1/1/%0d/%0d",
               reportValid, meanOut, minOut, maxOut, expMin, expMax);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) win[i] = (i % 2 == 0) ? -16'sd1 : -16'sd2;
    feedWindow();
`ifdef DDMTD_ACCUM_MINMAX_EN
    expMin = -16'sd2; expMax = -16'sd1;
`endif
    checks++;
    if (reportValid !== 1'b1 || meanOut !== -16'sd2 || minOut !== expMin || maxOut !== expMax) begin
      failures++;
      $display("[TB] FAIL alt_neg: valid=%b mean=%0d min=%0d max=%0d, expected 1/-2/%0d/%0d",
               reportValid, meanOut, minOut, maxOut, expMin, expMax);
    end
    @(negedge clk);
  endtask

  task automatic test_extreme();
    logic signed [15:0] expMin, expMax;
    reportReady = 1'b1;
    for (int i = 0; i < 16; i++) win[i] = (i < 8) ? 16'sh7FFF : 16'sh8000;
    feedWindow();
    expMin = 16'sd0; expMax = 16'sd0;
`ifdef DDMTD_ACCUM_MINMAX_EN
    expMin = 16'sh8000; expMax = 16'sh7FFF;
`endif
    checks++;
    if (reportValid !== 1'b1 || meanOut !== -16'sd1) begin
      failures++;
      $display("[TB] FAIL extreme_mean: valid=%b mean=%0d, expected 1/-1", reportValid, meanOut);
    end
    checks++;
    if (minOut !== expMin || maxOut !== expMax) begin
      failures++;
      $display("[TB] FAIL extreme_minmax: min=%0d max=%0d, expected %0d/%0d", minOut, maxOut, expMin, expMax);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    reportReady = 1'b0;
    fillConst(16'sd7);
    feedWindow();
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd7) begin
      failures++;
      $display("[TB] FAIL b2b_first: valid=%b mean=%0d, expected 1/7", reportValid, meanOut);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      phaseStrobe = 1'b1;
      phaseDiff   = 16'sd9;
      if (i == 15) reportReady = 1'b1;
    end
    @(negedge clk);
    phaseStrobe = 1'b0;
    reportReady = 1'b0;
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd9 || overrunCnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL b2b_switch: valid=%b mean=%0d ovr=%0d, expected 1/9/0", reportValid, meanOut, overrunCnt);
    end
    @(negedge clk);
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd9) begin
      failures++;
      $display("[TB] FAIL b2b_hold: valid=%b mean=%0d, expected 1/9", reportValid, meanOut);
    end
    reportReady = 1'b1;
    @(negedge clk);
    checks++;
    if (reportValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: valid=%b, expected 0", reportValid);
    end
  endtask

  task automatic test_overrun();
    reportReady = 1'b0;
    fillConst(16'sd10); feedWindow();
    fillConst(16'sd20); feedWindow();
    fillConst(16'sd30); feedWindow();
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd10 || overrunCnt !== 8'd2) begin
      failures++;
      $display("[TB] FAIL overrun_hold: valid=%b mean=%0d ovr=%0d, expected 1/10/2", reportValid, meanOut, overrunCnt);
    end
    reportReady = 1'b1;
    @(negedge clk);
    checks++;
    if (reportValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_accept: valid=%b, expected 0", reportValid);
    end
    fillConst(16'sd40); feedWindow();
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd40 || overrunCnt !== 8'd2) begin
      failures++;
      $display("[TB] FAIL overrun_next: valid=%b mean=%0d ovr=%0d, expected 1/40/2", reportValid, meanOut, overrunCnt);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    reportReady = 1'b0;
    fillConst(16'sd100); feedWindow();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      phaseStrobe = 1'b1;
      phaseDiff   = 16'sd1000;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    phaseStrobe = 1'b0;
    checks++;
    if (reportValid !== 1'b0 || meanOut !== 16'sd0 || minOut !== 16'sd0 ||
        maxOut !== 16'sd0 || overrunCnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: valid=%b mean=%0d min=%0d max=%0d ovr=%0d, expected all 0",
               reportValid, meanOut, minOut, maxOut, overrunCnt);
    end
    @(negedge clk);
    rst = 1'b0;
    reportReady = 1'b1;
    fillConst(16'sd5); feedWindow();
    checks++;
    if (reportValid !== 1'b1 || meanOut !== 16'sd5) begin
      failures++;
      $display("[TB] FAIL midreset_mean: valid=%b mean=%0d, expected 1/5", reportValid, meanOut);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_extreme();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
